// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB; R/I 4, LOAD 5, STORE 4, BRANCH 3 cycles.
// Memory backpressure: FETCH and MEM hold mem_req with stable address/direction until mem_ready.
module multicycle_sequencer #(
   parameter int CNT_W        = 16,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instruction,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             iord,
   output logic             memReadWrite,
   output logic             ir_write,
   output logic             pc_write,
   output logic             PCsrc,
   output logic             ALUsrc,
   output logic [1:0]       immSel,
   output logic [2:0]       ALUop,
   output logic             memToReg,
   output logic             RegWrite,
   output logic             retire,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_ILLEGAL
   } class_t;

   state_t           cur;
   logic [3:0]       opcode;
   logic [CNT_W-1:0] count;
   class_t           cls;
   logic [1:0]       dec_imm;
   logic             dec_src;
   logic [2:0]       dec_op;
   logic             alu_on;
   logic             unused_instr;

   assign unused_instr = ^{instruction[31:14], instruction[11:6], instruction[3:0]};
   assign state        = cur;
   assign instr_count  = count;

   always_comb begin
      cls     = CL_ILLEGAL;
      dec_imm = 2'b00;
      dec_src = 1'b0;
      dec_op  = 3'b000;
      case (opcode)
         4'b0011: begin cls = CL_R; end
         4'b1011: begin cls = CL_R; dec_op = 3'b001; end
         4'b0111: begin cls = CL_R; dec_op = 3'b010; end
         4'b0001: begin cls = CL_I; dec_imm = 2'b01; dec_src = 1'b1; end
         4'b1001: begin cls = CL_I; dec_imm = 2'b01; dec_src = 1'b1; dec_op = 3'b001; end
         4'b0101: begin cls = CL_I; dec_imm = 2'b01; dec_src = 1'b1; dec_op = 3'b010; end
         4'b1000: begin cls = CL_LOAD; dec_imm = 2'b01; dec_src = 1'b1; end
         4'b1010: begin cls = CL_STORE; dec_imm = 2'b10; dec_src = 1'b1; end
         4'b0010: begin cls = CL_BRANCH; dec_imm = 2'b11; dec_op = 3'b011; end
         default: ;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      iord         = 1'b0;
      memReadWrite = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      PCsrc        = 1'b0;
      memToReg     = 1'b0;
      RegWrite     = 1'b0;
      retire       = 1'b0;
      halted       = 1'b0;
      alu_on       = 1'b0;
      case (cur)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         DECODE: begin
            alu_on = 1'b1;
            // Without halting, an illegal opcode finishes here as a NOP
            if (cls == CL_ILLEGAL && !ILLEGAL_HALT) retire = 1'b1;
         end
         EXEC: begin
            alu_on = 1'b1;
            if (cls == CL_BRANCH) begin
               pc_write = zero;
               PCsrc    = zero;
               retire   = 1'b1;
            end
         end
         MEM: begin
            alu_on       = 1'b1;
            mem_req      = 1'b1;
            iord         = 1'b1;
            memReadWrite = (cls == CL_STORE);
            if (mem_ready && cls == CL_STORE) retire = 1'b1;
         end
         WB: begin
            alu_on   = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
            memToReg = (cls != CL_LOAD);
         end
         HALT: halted = 1'b1;
         default: ;
      endcase
      immSel = alu_on ? dec_imm : 2'b00;
      ALUsrc = alu_on ? dec_src : 1'b0;
      ALUop  = alu_on ? dec_op  : 3'b000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur    <= IDLE;
         opcode <= 4'b0000;
         count  <= '0;
      end else begin
         if (retire) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
         case (cur)
            IDLE:  cur <= FETCH;
            FETCH: begin
               if (mem_ready) begin
                  opcode <= {instruction[13:12], instruction[5:4]};
                  cur    <= DECODE;
               end
            end
            DECODE: begin
               if (cls == CL_ILLEGAL) cur <= ILLEGAL_HALT ? HALT : FETCH;
               else                   cur <= EXEC;
            end
            EXEC: begin
               case (cls)
                  CL_R, CL_I:         cur <= WB;
                  CL_LOAD, CL_STORE:  cur <= MEM;
                  default:            cur <= FETCH;
               endcase
            end
            MEM: begin
               if (mem_ready) cur <= (cls == CL_STORE) ? FETCH : WB;
            end
            WB:      cur <= FETCH;
            HALT:    cur <= HALT;
            default: cur <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction expected cycle traces built from the phase rules.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instruction = 32'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;

   always #5 clk = ~clk;

   logic a_mem_req, a_iord, a_mrw, a_ir_write, a_pc_write, a_pcsrc, a_alusrc;
   logic a_memtoreg, a_regwrite, a_retire, a_halted;
   logic [1:0] a_immsel;
   logic [2:0] a_aluop, a_state;
   logic [15:0] a_instr_count;

   logic b_mem_req, b_iord, b_mrw, b_ir_write, b_pc_write, b_pcsrc, b_alusrc;
   logic b_memtoreg, b_regwrite, b_retire, b_halted;
   logic [1:0] b_immsel;
   logic [2:0] b_aluop, b_state;
   logic [3:0] b_instr_count;

   multicycle_sequencer #(.CNT_W(16), .ILLEGAL_HALT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .mem_req(a_mem_req), .iord(a_iord), .memReadWrite(a_mrw), .ir_write(a_ir_write),
      .pc_write(a_pc_write), .PCsrc(a_pcsrc), .ALUsrc(a_alusrc), .immSel(a_immsel),
      .ALUop(a_aluop), .memToReg(a_memtoreg), .RegWrite(a_regwrite), .retire(a_retire),
      .halted(a_halted), .instr_count(a_instr_count), .state(a_state));

   multicycle_sequencer #(.CNT_W(4), .ILLEGAL_HALT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .mem_req(b_mem_req), .iord(b_iord), .memReadWrite(b_mrw), .ir_write(b_ir_write),
      .pc_write(b_pc_write), .PCsrc(b_pcsrc), .ALUsrc(b_alusrc), .immSel(b_immsel),
      .ALUop(b_aluop), .memToReg(b_memtoreg), .RegWrite(b_regwrite), .retire(b_retire),
      .halted(b_halted), .instr_count(b_instr_count), .state(b_state));

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, iord, mrw, ir_write, pc_write, pcsrc, alusrc;
      logic [1:0] immsel;
      logic [2:0] aluop;
      logic       memtoreg, regwrite, retire, halted;
   } exp_t;

   typedef struct {
      exp_t e;
      logic mr;
      logic zr;
      logic hs;
   } step_t;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] cnt_a = 16'd0;
   logic [3:0]  cnt_b = 4'd0;

   function automatic exp_t obs(input bit b);
      exp_t o;
      if (b) o = {b_state, b_mem_req, b_iord, b_mrw, b_ir_write, b_pc_write, b_pcsrc, b_alusrc,
                  b_immsel, b_aluop, b_memtoreg, b_regwrite, b_retire, b_halted};
      else   o = {a_state, a_mem_req, a_iord, a_mrw, a_ir_write, a_pc_write, a_pcsrc, a_alusrc,
                  a_immsel, a_aluop, a_memtoreg, a_regwrite, a_retire, a_halted};
      return o;
   endfunction

   // class codes: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 ILLEGAL
   function automatic void classify(input logic [3:0] op, output int c, output logic [1:0] is,
                                    output logic as, output logic [2:0] ao);
      c = 5; is = 2'b00; as = 1'b0; ao = 3'b000;
      case (op)
         4'b0011: begin c = 0; end
         4'b1011: begin c = 0; ao = 3'b001; end
         4'b0111: begin c = 0; ao = 3'b010; end
         4'b0001: begin c = 1; is = 2'b01; as = 1'b1; end
         4'b1001: begin c = 1; is = 2'b01; as = 1'b1; ao = 3'b001; end
         4'b0101: begin c = 1; is = 2'b01; as = 1'b1; ao = 3'b010; end
         4'b1000: begin c = 2; is = 2'b01; as = 1'b1; end
         4'b1010: begin c = 3; is = 2'b10; as = 1'b1; end
         4'b0010: begin c = 4; is = 2'b11; ao = 3'b011; end
         default: ;
      endcase
   endfunction

   function automatic step_t blank(input logic [2:0] st);
      step_t s;
      s.e    = '0;
      s.e.st = st;
      s.mr   = 1'($urandom_range(0, 1));
      s.zr   = 1'($urandom_range(0, 1));
      s.hs   = 1'b0;
      return s;
   endfunction

   task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input logic zv,
                            input bit on_b, input string name);
      step_t q[$];
      step_t s;
      exp_t o;
      int c;
      logic [1:0] is;
      logic as;
      logic [2:0] ao;
      logic [31:0] ins;
      classify(op, c, is, as, ao);
      ins = $urandom;
      ins[13:12] = op[3:2];
      ins[5:4]   = op[1:0];

      for (int i = 0; i < wf; i++) begin
         s = blank(3'd1); s.e.mem_req = 1'b1; s.mr = 1'b0; q.push_back(s);
      end
      s = blank(3'd1); s.e.mem_req = 1'b1; s.e.ir_write = 1'b1; s.e.pc_write = 1'b1;
      s.mr = 1'b1; s.hs = 1'b1; q.push_back(s);

      s = blank(3'd2); s.e.immsel = is; s.e.alusrc = as; s.e.aluop = ao;
      s.e.retire = (c == 5); q.push_back(s);

      if (c != 5) begin
         s = blank(3'd3); s.e.immsel = is; s.e.alusrc = as; s.e.aluop = ao;
         if (c == 4) begin
            s.zr = zv; s.e.pc_write = zv; s.e.pcsrc = zv; s.e.retire = 1'b1;
         end
         q.push_back(s);
         if (c == 2 || c == 3) begin
            for (int i = 0; i <= wm; i++) begin
               s = blank(3'd4); s.e.immsel = is; s.e.alusrc = as; s.e.aluop = ao;
               s.e.mem_req = 1'b1; s.e.iord = 1'b1; s.e.mrw = (c == 3);
               s.mr = (i == wm); s.e.retire = (i == wm) && (c == 3);
               q.push_back(s);
            end
         end
         if (c <= 2) begin
            s = blank(3'd5); s.e.immsel = is; s.e.alusrc = as; s.e.aluop = ao;
            s.e.regwrite = 1'b1; s.e.retire = 1'b1; s.e.memtoreg = (c != 2);
            q.push_back(s);
         end
      end

      foreach (q[i]) begin
         @(negedge clk);
         mem_ready   = q[i].mr;
         zero        = q[i].zr;
         instruction = q[i].hs ? ins : $urandom;
         #1;
         o = obs(on_b);
         tests++;
         if (o !== q[i].e) begin
            fails++;
            $display("FAIL %s op=%b step %0d: outputs got %h want %h", name, op, i, o, q[i].e);
         end
         if (c != 5) begin
            tests++;
            if (a_instr_count !== cnt_a) begin
               fails++;
               $display("FAIL %s count_a step %0d: got %0d want %0d", name, i, a_instr_count, cnt_a);
            end
         end
         tests++;
         if (b_instr_count !== cnt_b) begin
            fails++;
            $display("FAIL %s count_b step %0d: got %0d want %0d", name, i, b_instr_count, cnt_b);
         end
         if (q[i].e.retire) begin
            if (c != 5) cnt_a++;
            cnt_b++;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (obs(0) !== exp_t'(0) || obs(1) !== exp_t'(0)) begin
         fails++;
         $display("FAIL reset_outputs: got %h / %h want 0", obs(0), obs(1));
      end
      tests++;
      if (a_instr_count !== 16'd0 || b_instr_count !== 4'd0) begin
         fails++;
         $display("FAIL reset_count: got %0d / %0d want 0", a_instr_count, b_instr_count);
      end
      rst = 1'b0;
      cnt_a = 16'd0;
      cnt_b = 4'd0;
   endtask

   task automatic test_r_add();
      run_instr(4'b0011, 0, 0, 1'b0, 1'b0, "r_add");
   endtask

   task automatic test_load_wait();
      run_instr(4'b1000, 2, 2, 1'b0, 1'b0, "load_wait");
   endtask

   task automatic test_store();
      run_instr(4'b1010, 0, 1, 1'b0, 1'b0, "store");
   endtask

   task automatic test_branch();
      run_instr(4'b0010, 0, 0, 1'b1, 1'b0, "branch_taken");
      run_instr(4'b0010, 0, 0, 1'b0, 1'b0, "branch_not_taken");
   endtask

   task automatic test_random();
      logic [3:0] legal [9] = '{4'b0011, 4'b1011, 4'b0111, 4'b0001, 4'b1001,
                                4'b0101, 4'b1000, 4'b1010, 4'b0010};
      for (int n = 0; n < 30; n++)
         run_instr(legal[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'b0, "random");
   endtask

   task automatic test_rst_mid();
      logic [31:0] ins;
      ins = $urandom;
      ins[13:12] = 2'b10;
      ins[5:4]   = 2'b00;
      @(negedge clk); mem_ready = 1'b1; instruction = ins;
      @(negedge clk); mem_ready = 1'b0; instruction = $urandom;
      @(negedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (a_state !== 3'd4 || a_mem_req !== 1'b1 || a_iord !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_in_mem: state %0d req %b iord %b want 4 1 1", a_state, a_mem_req, a_iord);
      end
      @(negedge clk); rst = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (obs(0) !== exp_t'(0) || obs(1) !== exp_t'(0)) begin
         fails++;
         $display("FAIL rst_mid_idle: got %h / %h want 0", obs(0), obs(1));
      end
      tests++;
      if (a_instr_count !== 16'd0 || b_instr_count !== 4'd0) begin
         fails++;
         $display("FAIL rst_mid_count: got %0d / %0d want 0", a_instr_count, b_instr_count);
      end
      rst = 1'b0;
      cnt_a = 16'd0;
      cnt_b = 4'd0;
      run_instr(4'b0011, 0, 0, 1'b0, 1'b0, "after_rst_mid");
   endtask

   task automatic test_wrap();
      logic [3:0] legal [9] = '{4'b0011, 4'b1011, 4'b0111, 4'b0001, 4'b1001,
                                4'b0101, 4'b1000, 4'b1010, 4'b0010};
      for (int n = 0; n < 15; n++)
         run_instr(legal[$urandom_range(0, 8)], 0, $urandom_range(0, 1),
                   1'($urandom_range(0, 1)), 1'b0, "wrap");
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      tests++;
      if (b_instr_count !== 4'd0) begin
         fails++;
         $display("FAIL wrap_b: got %0d want 0", b_instr_count);
      end
      tests++;
      if (a_instr_count !== 16'd16) begin
         fails++;
         $display("FAIL wrap_a: got %0d want 16", a_instr_count);
      end
   endtask

   task automatic test_illegal();
      exp_t h;
      run_instr(4'b1111, 1, 0, 1'b0, 1'b1, "illegal_nohalt");
      h = '0;
      h.st = 3'd6;
      h.halted = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready   = 1'($urandom_range(0, 1));
         zero        = 1'($urandom_range(0, 1));
         instruction = $urandom;
         #1;
         tests++;
         if (obs(0) !== h) begin
            fails++;
            $display("FAIL halt_sticky cycle %0d: got %h want %h", i, obs(0), h);
         end
         if (i == 0) begin
            tests++;
            if (b_state !== 3'd1) begin
               fails++;
               $display("FAIL nohalt_refetch: state got %0d want 1", b_state);
            end
         end
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (a_halted !== 1'b0 || a_state !== 3'd0) begin
         fails++;
         $display("FAIL halt_cleared: halted %b state %0d want 0 0", a_halted, a_state);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_r_add();
      test_load_wait();
      test_store();
      test_branch();
      test_random();
      test_rst_mid();
      test_wrap();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
